// File: rtl/cla_frame_accum_pkg.sv
// -----------------------------------------------------------------------------
// cla_frame_accum_pkg
// Shared definitions for the frame accumulator: FSM state encoding, operand
// and pair-sum widths, and the pair-sum helper used by the top.
// -----------------------------------------------------------------------------
package cla_frame_accum_pkg;

    localparam int OPW = 11;   // operand width from the upstream adder stage
    localparam int PSW = 12;   // pair-sum width: {carry, sum}

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // 12-bit pair sum of zero-extended operands; bit 11 is the carry out.
    function automatic logic [PSW-1:0] pair_sum(input logic [OPW-1:0] a,
                                                input logic [OPW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/cla_frame_accum_if.sv
// -----------------------------------------------------------------------------
// cla_frame_accum_if
// Bundles the operand-pair handshake and the frame-result handshake.
//   i_valid / o_ready        : operand pair handshake
//   i_add1 / i_add2          : 11-bit operands
//   o_frame_valid / i_frame_ready : frame result handshake
//   o_frame_sum (ACC_W), o_ovf    : frame result
// Modports: master = producer/consumer side (testbench), slave = accumulator.
// -----------------------------------------------------------------------------
interface cla_frame_accum_if #(
    parameter int ACC_W = 16
);
    import cla_frame_accum_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [OPW-1:0]   i_add1;
    logic [OPW-1:0]   i_add2;
    logic             o_frame_valid;
    logic             i_frame_ready;
    logic [ACC_W-1:0] o_frame_sum;
    logic             o_ovf;

    modport master (
        output i_valid, i_add1, i_add2, i_frame_ready,
        input  o_ready, o_frame_valid, o_frame_sum, o_ovf
    );

    modport slave (
        input  i_valid, i_add1, i_add2, i_frame_ready,
        output o_ready, o_frame_valid, o_frame_sum, o_ovf
    );

endinterface

// File: rtl/cla_frame_accum_add.sv
// -----------------------------------------------------------------------------
// cla_acc_add
// Combinational ACC_W-bit accumulate of a 12-bit pair sum.
//   acc_i : current accumulator
//   ps_i  : 12-bit pair sum, zero-extended before the add
//   acc_o : next accumulator value
//   cy_o  : carry out of bit ACC_W-1 (overflow indication)
// Build option: CLA_FRAME_ACCUM_SAT_EN clamps acc_o to all-ones on carry;
// otherwise the result wraps modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module cla_acc_add
    import cla_frame_accum_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [PSW-1:0]   ps_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             cy_o
);

    logic [ACC_W:0] sum;

    assign sum  = {1'b0, acc_i} + (ACC_W+1)'(ps_i);
    assign cy_o = sum[ACC_W];

`ifdef CLA_FRAME_ACCUM_SAT_EN
    // Once clamped, any further non-zero add carries again and re-clamps,
    // so the value stays pinned for the rest of the frame.
    assign acc_o = cy_o ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_o = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/cla_frame_accum.sv
// -----------------------------------------------------------------------------
// cla_frame_accum
// Streaming accumulator: captures 11-bit operand pairs, forms their 12-bit
// sums and accumulates FRAME_LEN of them into an ACC_W-bit frame total that
// is offered on a result handshake.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : cla_frame_accum_if.slave (pair handshake + frame result)
// Build option: CLA_FRAME_ACCUM_SAT_EN (saturating accumulate, in cla_acc_add).
// Pipeline: stage 1 registers the accepted pair, stage 2 adds its sum into
// the accumulator one cycle later. DRAIN covers that last stage-2 add.
// -----------------------------------------------------------------------------
module cla_frame_accum
    import cla_frame_accum_pkg::*;
#(
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cla_frame_accum_if.slave bus
);

    localparam int             CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [OPW-1:0]   opa_q, opb_q;
    logic             s1_vld_q;
    logic [ACC_W-1:0] acc_q, acc_nxt;
    logic             ovf_q, add_cy;
    logic             ready, accept, clr;

    // Ready is a function of state only (plus reset), never of i_valid.
    assign ready   = !i_rst && ((state_q == IDLE) ||
                                (state_q == ACCUM && cnt_q < CNT_LAST));
    assign accept  = bus.i_valid && ready;
    assign cnt_inc = cnt_q + 1'b1;

    cla_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc_i (acc_q),
        .ps_i  (pair_sum(opa_q, opb_q)),
        .acc_o (acc_nxt),
        .cy_o  (add_cy)
    );

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = (FRAME_LEN == 1) ? DRAIN : ACCUM;
            ACCUM: if (accept && cnt_inc == CNT_LAST) state_d = DRAIN;
            DRAIN: state_d = HOLD;
            HOLD: begin
                if (bus.i_frame_ready) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)         cnt_d = '0;
        else if (accept) cnt_d = cnt_inc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= accept;
            if (accept) begin
                opa_q <= bus.i_add1;
                opb_q <= bus.i_add2;
            end
            // clr only fires in HOLD, where stage 1 is always empty.
            if (clr) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (s1_vld_q) begin
                acc_q <= acc_nxt;
                ovf_q <= ovf_q | add_cy;
            end
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_frame_valid = (state_q == HOLD);
    assign bus.o_frame_sum   = acc_q;
    assign bus.o_ovf         = ovf_q;

endmodule
